datapath: RTL and testbench

- Single-cycle register-file + ALU datapath.
- Two read ports feed a 32-bit ALU. The ALU result is always visible on `result` and is written back into the register file on a write-enabled clock edge.
- Used as the execution core of a small processor/ALU exercise. There is no external data input: all register contents derive from reset values and ALU writeback.

---
 rtl/datapath_pkg.sv | 18 +
 rtl/datapath_alu32.sv | 32 +++
 rtl/datapath.sv | 57 +++++
 tb/tb_datapath.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared constants for the register-file + ALU datapath.
// Word width, register file geometry and ALU opcode encodings.
package datapath_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int NREGS     = 4;
    localparam int AW        = 2;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

endpackage

// File: rtl/datapath_alu32.sv
// Combinational ALU: eight ops on two unsigned words.
// Carry is only produced by ADD/SUB; SUB carry=1 means no borrow.
module alu32
    import datapath_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             cout
);

    // Fully decoded op select; every path assigns y and cout.
    always_comb begin
        y    = '0;
        cout = 1'b0;
        unique case (op)
            OP_AND:  y = a & b;
            OP_ADD:  {cout, y} = {1'b0, a} + {1'b0, b};
            OP_SUB:  {cout, y} = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            OP_SLT:  y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_PASS: y = a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/datapath.sv
// Single-cycle datapath: 4-entry register file feeding alu32.
// The ALU result is written back to R[addr3] on enabled edges.
module datapath
    import datapath_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [AW-1:0]    addr1,
    input  logic [AW-1:0]    addr2,
    input  logic [AW-1:0]    addr3,
    input  logic             clk,
    input  logic             wr,
    input  logic             rst,
    input  logic [2:0]       alu,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    logic [WIDTH-1:0] rf_q [NREGS];
    logic [WIDTH-1:0] rf_d [NREGS];
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    // Asynchronous read ports.
    always_comb begin
        op_a = rf_q[addr1];
        op_b = rf_q[addr2];
    end

    alu32 #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a    (op_a),
        .b    (op_b),
        .op   (alu),
        .y    (result),
        .cout (cout)
    );

    // Next register state: reset to index values beats writeback.
    always_comb begin
        rf_d = rf_q;
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_d[i] = WIDTH'(i);
            end
        end else if (wr) begin
            rf_d[addr3] = result;
        end
    end

    // Register file state update.
    always_ff @(posedge clk) begin
        rf_q <= rf_d;
    end

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: reference model plus
// directed vectors with hand-computed expectations.
module tb_datapath;

    logic [1:0]  addr1;
    logic [1:0]  addr2;
    logic [1:0]  addr3;
    logic        clk;
    logic        wr;
    logic        rst;
    logic [2:0]  alu;
    logic [31:0] result;
    logic        cout;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    logic [31:0] m [4];

    datapath dut (
        .addr1  (addr1),
        .addr2  (addr2),
        .addr3  (addr3),
        .clk    (clk),
        .wr     (wr),
        .rst    (rst),
        .alu    (alu),
        .result (result),
        .cout   (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_alu(
        input  logic [31:0] a,
        input  logic [31:0] b,
        input  logic [2:0]  op,
        output logic [31:0] y,
        output logic        c
    );
        longint unsigned s;
        int sa;
        int sb;
        y = 32'd0;
        c = 1'b0;
        sa = a;
        sb = b;
        case (op)
            3'd0: y = a & b;
            3'd1: begin
                s = longint'(a) + longint'(b);
                y = s[31:0];
                c = (s >= 64'h1_0000_0000);
            end
            3'd2: begin
                s = 64'h1_0000_0000 + longint'(a) - longint'(b);
                y = s[31:0];
                c = (a >= b);
            end
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: y = ~(a | b);
            3'd6: y = (sa < sb) ? 32'd1 : 32'd0;
            default: y = a;
        endcase
    endfunction

    task automatic check(
        input string       name,
        input logic [31:0] got_y,
        input logic        got_c,
        input logic [31:0] exp_y,
        input logic        exp_c
    );
        checks++;
        if (got_y !== exp_y || got_c !== exp_c) begin
            errors++;
            $display("FAIL %s: got result=%h cout=%b, want result=%h cout=%b",
                     name, got_y, got_c, exp_y, exp_c);
        end
    endtask

    // Model register file follows the architectural rules.
    always @(posedge clk) begin
        logic [31:0] y;
        logic        c;
        if (rst) begin
            for (int i = 0; i < 4; i++) m[i] = i;
        end else if (wr) begin
            model_alu(m[addr1], m[addr2], alu, y, c);
            m[addr3] = y;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        logic [31:0] y;
        logic        c;
        if (chk_en) begin
            model_alu(m[addr1], m[addr2], alu, y, c);
            check("cycle", result, cout, y, c);
        end
    end

    task automatic drive(
        input logic [1:0] a1,
        input logic [1:0] a2,
        input logic [1:0] a3,
        input logic       w,
        input logic       r,
        input logic [2:0] op
    );
        @(negedge clk);
        #1;
        addr1 = a1;
        addr2 = a2;
        addr3 = a3;
        wr    = w;
        rst   = r;
        alu   = op;
        #1;
    endtask

    initial begin
        addr1 = 2'd0;
        addr2 = 2'd0;
        addr3 = 2'd0;
        wr    = 1'b0;
        rst   = 1'b1;
        alu   = 3'd0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        drive(1, 2, 0, 0, 0, 3'b001);
        check("rst_add", result, cout, 32'd3, 1'b0);
        drive(3, 3, 0, 0, 0, 3'b000);
        check("rst_and33", result, cout, 32'd3, 1'b0);

        drive(1, 1, 1, 1, 0, 3'b001);
        check("add_pre_wb", result, cout, 32'd2, 1'b0);
        drive(1, 0, 0, 0, 0, 3'b111);
        check("add_wb_r1", result, cout, 32'd2, 1'b0);

        drive(0, 0, 0, 0, 1, 3'b000);
        drive(0, 1, 0, 0, 0, 3'b010);
        check("sub_borrow", result, cout, 32'hFFFF_FFFF, 1'b0);
        drive(3, 2, 0, 0, 0, 3'b010);
        check("sub_noborrow", result, cout, 32'd1, 1'b1);

        drive(0, 1, 0, 1, 0, 3'b010);
        drive(0, 1, 0, 0, 0, 3'b001);
        check("add_carry", result, cout, 32'd0, 1'b1);
        drive(0, 1, 0, 0, 0, 3'b110);
        check("slt_neg", result, cout, 32'd1, 1'b0);
        drive(1, 0, 0, 0, 0, 3'b110);
        check("slt_pos", result, cout, 32'd0, 1'b0);
        drive(1, 0, 0, 0, 0, 3'b010);
        check("sub_1_m1", result, cout, 32'd2, 1'b0);

        drive(0, 0, 0, 0, 1, 3'b000);
        drive(2, 3, 0, 0, 0, 3'b000);
        check("and_23", result, cout, 32'd2, 1'b0);
        drive(2, 3, 0, 0, 0, 3'b011);
        check("or_23", result, cout, 32'd3, 1'b0);
        drive(2, 3, 0, 0, 0, 3'b100);
        check("xor_23", result, cout, 32'd1, 1'b0);
        drive(2, 3, 0, 0, 0, 3'b101);
        check("nor_23", result, cout, 32'hFFFF_FFFC, 1'b0);

        drive(2, 2, 2, 1, 0, 3'b001);
        drive(2, 3, 2, 1, 1, 3'b011);
        drive(2, 2, 0, 0, 0, 3'b111);
        check("rst_prio_r2", result, cout, 32'd2, 1'b0);

        drive(3, 3, 3, 1, 0, 3'b001);
        for (int k = 0; k < 8; k++) begin
            drive(2'(k), 2'(k + 1), 2'(k), 0, 0, 3'(k));
        end
        drive(0, 0, 0, 0, 0, 3'b111);
        check("hold_r0", result, cout, 32'd0, 1'b0);
        drive(1, 0, 1, 0, 0, 3'b111);
        check("hold_r1", result, cout, 32'd1, 1'b0);
        drive(2, 0, 2, 0, 0, 3'b111);
        check("hold_r2", result, cout, 32'd2, 1'b0);
        drive(3, 0, 3, 0, 0, 3'b111);
        check("hold_r3", result, cout, 32'd6, 1'b0);

        drive(3, 3, 3, 0, 0, 3'b000);
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
